// File: rtl/vga_pkg.sv
// Shared definitions for the push-button input stage: direction indices,
// per-button state type and a counter-width helper.
package vga_pkg;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Bits needed to hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button inputs and conditioned outputs of the button stage.
// The slave side is the conditioner; the master side drives the raw buttons.
interface btn_conditioner_if;

    logic       btn_up_raw;
    logic       btn_down_raw;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] btn_level;

    modport master (
        output btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
        input  up, down, left, right, btn_level
    );

    modport slave (
        input  btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw,
        output up, down, left, right, btn_level
    );

endinterface

// File: rtl/btn_conditioner_debounce.sv
// Per-button synchroniser, debouncer and press/repeat FSM.
// Hold-to-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
//
// state  | meaning
// IDLE   | stable level low, waiting for a debounced press
// HOLD   | pressed; waiting for release (or the first repeat delay)
// REPEAT | held past the first delay; periodic repeat candidates
module btn_debounce
    import vga_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic cand_o
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic           sync1_q;
    logic           sync2_q;
    logic           stable_q;
    logic           stable_d;
    logic [DBW-1:0] db_cnt_q;
    logic [DBW-1:0] db_cnt_d;
    btn_state_t     state_q;
    btn_state_t     state_d;
    logic           cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // The cycle that would bring the mismatch count to DB_CYCLES flips the level.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Release is tested first so it always beats a repeat in the same cycle.
    always_comb begin
        state_d   = state_q;
        cand      = 1'b0;
        rep_cnt_d = rep_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                rep_cnt_d = '0;
                if (stable_q) begin
                    state_d = HOLD;
                    cand    = 1'b1;
                end
            end
            HOLD: begin
                if (!stable_q) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == HOLD_LAST) begin
                    state_d   = REPEAT;
                    cand      = 1'b1;
                    rep_cnt_d = '0;
                end
            end
            REPEAT: begin
                if (!stable_q) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    cand      = 1'b1;
                    rep_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand    = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable_q) begin
                    state_d = HOLD;
                    cand    = 1'b1;
                end
            end
            HOLD: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
`endif

    assign level_o = stable_q;
    assign cand_o  = cand;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button input stage: debounced levels plus one-hot direction strobes.
// Auto-repeat per button is enabled with BTN_AUTO_REPEAT_EN.
module btn_conditioner
    import vga_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    btn_conditioner_if.slave   bus
);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] cand;
    logic [3:0] strobe_d;
    logic [3:0] strobe_q;
    logic [3:0] level_q;

    assign raw[DIR_UP]    = bus.btn_up_raw;
    assign raw[DIR_DOWN]  = bus.btn_down_raw;
    assign raw[DIR_LEFT]  = bus.btn_left_raw;
    assign raw[DIR_RIGHT] = bus.btn_right_raw;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[g]),
            .level_o (level[g]),
            .cand_o  (cand[g])
        );
    end

    // Fixed priority right > left > up > down; losers are simply dropped.
    always_comb begin
        strobe_d = '0;
        if (cand[DIR_RIGHT]) begin
            strobe_d[DIR_RIGHT] = 1'b1;
        end else if (cand[DIR_LEFT]) begin
            strobe_d[DIR_LEFT] = 1'b1;
        end else if (cand[DIR_UP]) begin
            strobe_d[DIR_UP] = 1'b1;
        end else if (cand[DIR_DOWN]) begin
            strobe_d[DIR_DOWN] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
            level_q  <= '0;
        end else begin
            strobe_q <= strobe_d;
            level_q  <= level;
        end
    end

    assign bus.up        = strobe_q[DIR_UP];
    assign bus.down      = strobe_q[DIR_DOWN];
    assign bus.left      = strobe_q[DIR_LEFT];
    assign bus.right     = strobe_q[DIR_RIGHT];
    assign bus.btn_level = level_q;

endmodule
